ingress_port: RTL and testbench

Parametrised ingress port for the FPGA switch. It receives fixed-size packet blocks from the packet generator, stores them in on-chip data memory, and queues each block's slot index in one of EGRESS_CNT virtual output queues (VOQs) selected by the header. On a scheduler grant it streams the head block of the granted VOQ to the crossbar and recycles the slot.

---
 rtl/ingress_pkg.sv | 28 ++
 rtl/ingress_port_slot_fifo.sv | 50 +++++
 rtl/ingress_port.sv | 217 +++++++++++++++++++++
 tb/tb_ingress_port.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_pkg.sv
// ingress_pkg: shared constants and types for the ingress port.
// Default geometry, FSM encodings and header field positions.
package ingress_pkg;
  localparam int SLOT_CNT_DEF    = 64;
  localparam int EGRESS_CNT_DEF  = 4;
  localparam int BLOCK_WORDS_DEF = 8;

  localparam int SLOT_W = $clog2(SLOT_CNT_DEF);
  localparam int SEL_W  = $clog2(EGRESS_CNT_DEF);
  localparam int WORD_W = $clog2(BLOCK_WORDS_DEF);

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [SEL_W-1:0]  sel_t;

  typedef logic [1:0] in_state_t;
  typedef logic [1:0] out_state_t;

  localparam in_state_t IN_IDLE = 2'd0;
  localparam in_state_t IN_RECV = 2'd1;
  localparam in_state_t IN_DROP = 2'd2;

  localparam out_state_t OUT_IDLE  = 2'd0;
  localparam out_state_t OUT_READ  = 2'd1;
  localparam out_state_t OUT_DRAIN = 2'd2;

  // Destination VOQ index sits in the low bits of the header word.
  localparam int HDR_DEST_LSB = 0;
endpackage

// File: rtl/ingress_port_slot_fifo.sv
// ingress_port_slot_fifo: circular FIFO of slot indices (show-ahead).
// Ports: clk_i/reset_i, push_i+din_i, pop_i, dout_o (head), empty_o, count_o.
module ingress_port_slot_fifo
  import ingress_pkg::*;
#(
  parameter int DEPTH = SLOT_CNT_DEF,
  parameter int W     = SLOT_W
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/ingress_port.sv
// ingress_port: stores fixed-size blocks, queues slots per VOQ,
// streams granted blocks to the crossbar and recycles the slot.
// Ports: packet_in/packet_en (blocks in), sched_sel/sched_done (grant),
// voq_nonempty (requests), busy_out, packet_out/packet_out_en,
// drop_cnt (saturating), grant_err (ignored-grant pulse).
module ingress_port
  import ingress_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int SLOT_CNT    = 64,
  parameter int EGRESS_CNT  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         packet_in,
  input  logic                          packet_en,
  input  logic [$clog2(EGRESS_CNT)-1:0] sched_sel,
  input  logic                          sched_done,
  output logic [EGRESS_CNT-1:0]         voq_nonempty,
  output logic                          busy_out,
  output logic [DATA_WIDTH-1:0]         packet_out,
  output logic                          packet_out_en,
  output logic [15:0]                   drop_cnt,
  output logic                          grant_err
);
  localparam int SLOT_BITS = $clog2(SLOT_CNT);
  localparam int SEL_BITS  = $clog2(EGRESS_CNT);
  localparam int WORD_BITS = $clog2(BLOCK_WORDS);
  localparam int ADDR_BITS = SLOT_BITS + WORD_BITS;
  localparam int CNT_BITS  = $clog2(SLOT_CNT + 1);
  localparam int MEM_DEPTH = SLOT_CNT * BLOCK_WORDS;

  in_state_t             in_state_q, in_state_d;
  logic [WORD_BITS-1:0]  in_cnt_q, in_cnt_d;
  logic [SLOT_BITS-1:0]  in_slot_q, in_slot_d;
  logic [SEL_BITS-1:0]   in_dest_q, in_dest_d;
  logic [15:0]           drop_q, drop_d;
  logic                  init_q;
  logic [SLOT_BITS-1:0]  init_cnt_q;

  out_state_t            out_state_q, out_state_d;
  logic [WORD_BITS-1:0]  out_cnt_q, out_cnt_d;
  logic [SLOT_BITS-1:0]  out_slot_q, out_slot_d;
  logic                  busy_q, busy_d;
  logic                  rd_v_q, last1_q, last2_q;
  logic [DATA_WIDTH-1:0] pout_q, rdata_q;
  logic                  pout_en_q, gerr_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  rd_en;

  logic                  free_push, free_pop, free_empty, free_ok;
  logic [SLOT_BITS-1:0]  free_din, free_head;
  logic [CNT_BITS-1:0]   free_cnt;
  logic                  unused_free;
  logic [EGRESS_CNT-1:0] voq_push, voq_pop, voq_empty;
  logic [SLOT_BITS-1:0]  voq_head [EGRESS_CNT];
  logic                  grant_ok;

  // While the post-reset walk refills the free list, headers see no
  // free slot and are dropped.
  assign free_push   = init_q || (out_state_q == OUT_DRAIN);
  assign free_din    = init_q ? init_cnt_q : out_slot_q;
  assign free_ok     = !init_q && !free_empty;
  assign unused_free = ^free_cnt;

  ingress_port_slot_fifo #(.DEPTH(SLOT_CNT), .W(SLOT_BITS)) u_free (
    .clk_i(clk), .reset_i(reset),
    .push_i(free_push), .din_i(free_din),
    .pop_i(free_pop), .dout_o(free_head),
    .empty_o(free_empty), .count_o(free_cnt)
  );

  for (genvar e = 0; e < EGRESS_CNT; e++) begin : g_voq
    logic [CNT_BITS-1:0] unused_cnt;
    ingress_port_slot_fifo #(.DEPTH(SLOT_CNT), .W(SLOT_BITS)) u_voq (
      .clk_i(clk), .reset_i(reset),
      .push_i(voq_push[e]), .din_i(in_slot_q),
      .pop_i(voq_pop[e]), .dout_o(voq_head[e]),
      .empty_o(voq_empty[e]), .count_o(unused_cnt)
    );
  end

  always_comb begin
    in_state_d = in_state_q;
    in_cnt_d   = in_cnt_q;
    in_slot_d  = in_slot_q;
    in_dest_d  = in_dest_q;
    drop_d     = drop_q;
    free_pop   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = {in_slot_q, in_cnt_q};
    voq_push   = '0;
    unique case (in_state_q)
      IN_IDLE: begin
        if (packet_en) begin
          in_dest_d = packet_in[HDR_DEST_LSB +: SEL_BITS];
          in_cnt_d  = WORD_BITS'(1);
          if (free_ok) begin
            free_pop   = 1'b1;
            in_slot_d  = free_head;
            mem_we     = 1'b1;
            mem_waddr  = {free_head, {WORD_BITS{1'b0}}};
            in_state_d = IN_RECV;
          end else begin
            in_state_d = IN_DROP;
          end
        end
      end
      IN_RECV: begin
        // Mid-block words are taken every cycle regardless of packet_en.
        mem_we   = 1'b1;
        in_cnt_d = in_cnt_q + 1'b1;
        if (&in_cnt_q) begin
          voq_push[in_dest_q] = 1'b1;
          in_state_d          = IN_IDLE;
        end
      end
      IN_DROP: begin
        in_cnt_d = in_cnt_q + 1'b1;
        if (&in_cnt_q) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          in_state_d = IN_IDLE;
        end
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  // busy_q covers the whole readout pipeline, so a clear busy_q also
  // implies the output FSM is idle.
  assign grant_ok = sched_done && !busy_q && !voq_empty[sched_sel];
  assign voq_pop  = grant_ok ? (EGRESS_CNT'(1) << sched_sel) : '0;
  assign busy_d   = grant_ok || (busy_q && !last2_q);
  assign rd_en    = (out_state_q == OUT_READ);
  assign rd_addr  = {out_slot_q, out_cnt_q};

  always_comb begin
    out_state_d = out_state_q;
    out_cnt_d   = out_cnt_q;
    out_slot_d  = out_slot_q;
    unique case (out_state_q)
      OUT_IDLE: begin
        if (grant_ok) begin
          out_slot_d  = voq_head[sched_sel];
          out_cnt_d   = '0;
          out_state_d = OUT_READ;
        end
      end
      OUT_READ: begin
        out_cnt_d = out_cnt_q + 1'b1;
        if (&out_cnt_q) out_state_d = OUT_DRAIN;
      end
      OUT_DRAIN: out_state_d = OUT_IDLE;
      default:   out_state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q  <= IN_IDLE;
      in_cnt_q    <= '0;
      in_slot_q   <= '0;
      in_dest_q   <= '0;
      drop_q      <= '0;
      init_q      <= 1'b1;
      init_cnt_q  <= '0;
      out_state_q <= OUT_IDLE;
      out_cnt_q   <= '0;
      out_slot_q  <= '0;
      busy_q      <= 1'b0;
      rd_v_q      <= 1'b0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
      pout_q      <= '0;
      pout_en_q   <= 1'b0;
      gerr_q      <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      in_cnt_q    <= in_cnt_d;
      in_slot_q   <= in_slot_d;
      in_dest_q   <= in_dest_d;
      drop_q      <= drop_d;
      if (init_q) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (&init_cnt_q) init_q <= 1'b0;
      end
      out_state_q <= out_state_d;
      out_cnt_q   <= out_cnt_d;
      out_slot_q  <= out_slot_d;
      busy_q      <= busy_d;
      // Address -> rdata_q -> pout_q: two stages after issue.
      rd_v_q      <= rd_en;
      last1_q     <= rd_en && (&out_cnt_q);
      last2_q     <= last1_q;
      pout_en_q   <= rd_v_q;
      pout_q      <= rd_v_q ? rdata_q : '0;
      gerr_q      <= sched_done && !grant_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= packet_in;
    rdata_q <= mem_q[rd_addr];
  end

  assign voq_nonempty  = ~voq_empty;
  assign busy_out      = busy_q;
  assign packet_out    = pout_q;
  assign packet_out_en = pout_en_q;
  assign drop_cnt      = drop_q;
  assign grant_err     = gerr_q;
endmodule

// File: tb/tb_ingress_port.sv
// tb_ingress_port: directed bench on a 4-slot, 4-VOQ, 8-word port.
// Expected words are rebuilt from (tag, dest, index) by wd().
module tb_ingress_port;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int SC = 4;
  localparam int EG = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] packet_in = '0;
  logic          packet_en = 1'b0;
  logic [1:0]    sched_sel = '0;
  logic          sched_done = 1'b0;
  logic [EG-1:0] voq_nonempty;
  logic          busy_out;
  logic [DW-1:0] packet_out;
  logic          packet_out_en;
  logic [15:0]   drop_cnt;
  logic          grant_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ingress_port #(
    .DATA_WIDTH(DW), .BLOCK_WORDS(BW),
    .SLOT_CNT(SC), .EGRESS_CNT(EG)
  ) dut (
    .clk(clk), .reset(reset),
    .packet_in(packet_in), .packet_en(packet_en),
    .sched_sel(sched_sel), .sched_done(sched_done),
    .voq_nonempty(voq_nonempty), .busy_out(busy_out),
    .packet_out(packet_out), .packet_out_en(packet_out_en),
    .drop_cnt(drop_cnt), .grant_err(grant_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit 3 is set in every word: a header bit above the dest field.
  function automatic logic [31:0] wd(input int tag, input int dest,
                                     input int i);
    return 32'((tag << 8) | (i << 4) | 8 | dest);
  endfunction

  task automatic send(input int tag, input int dest);
    for (int i = 0; i < BW; i++) begin
      packet_in = wd(tag, dest, i);
      packet_en = 1'b1;
      tick();
    end
    packet_en = 1'b0;
  endtask

  task automatic grant(input int sel);
    sched_sel  = 2'(sel);
    sched_done = 1'b1;
    tick();
    sched_done = 1'b0;
  endtask

  task automatic expect_block(input int tag, input int dest,
                              input bit inject);
    check("busy_rise", busy_out, 1);
    tick();
    check("lat_en", packet_out_en, 0);
    for (int i = 0; i < BW; i++) begin
      tick();
      check("word_en", packet_out_en, 1);
      check("word", packet_out, wd(tag, dest, i));
      if (inject && i == 2) begin
        sched_sel  = 2'(dest);
        sched_done = 1'b1;
      end
      if (inject && i == 3) begin
        check("gerr_busy", grant_err, 1);
        sched_done = 1'b0;
      end
    end
    check("busy_hold", busy_out, 1);
    tick();
    check("end_en", packet_out_en, 0);
    check("busy_fall", busy_out, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check("rst_nonempty", voq_nonempty, 0);
    check("rst_busy", busy_out, 0);
    check("rst_en", packet_out_en, 0);
    check("rst_out", packet_out, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_gerr", grant_err, 0);
    reset = 1'b0;
    repeat (6) tick();
    check("init_free", dut.free_cnt, 4);

    send(16'h10, 2);
    check("t1_nonempty", voq_nonempty, 4'b0100);
    check("t1_free", dut.free_cnt, 3);
    grant(2);
    expect_block(16'h10, 2, 1'b0);
    check("t1_empty", voq_nonempty, 0);
    check("t1_free_back", dut.free_cnt, 4);

    for (int d = 0; d < 4; d++) send(16'h20 + d, d);
    check("t2_nonempty", voq_nonempty, 4'b1111);
    check("t2_free", dut.free_cnt, 0);
    for (int d = 3; d >= 0; d--) begin
      grant(d);
      expect_block(16'h20 + d, d, 1'b0);
    end
    send(16'h2A, 1);
    send(16'h2B, 1);
    grant(1);
    expect_block(16'h2A, 1, 1'b0);
    grant(1);
    expect_block(16'h2B, 1, 1'b0);
    check("t2_free_back", dut.free_cnt, 4);

    for (int n = 0; n < 5; n++) send(16'h30 + n, n % 4);
    check("t3_drop", drop_cnt, 1);
    check("t3_nonempty", voq_nonempty, 4'b1111);
    grant(0);
    expect_block(16'h30, 0, 1'b0);
    send(16'h35, 0);
    check("t3_drop_keep", drop_cnt, 1);
    check("t3_free", dut.free_cnt, 0);
    for (int d = 1; d < 4; d++) begin
      grant(d);
      expect_block(16'h30 + d, d, 1'b0);
    end
    grant(0);
    expect_block(16'h35, 0, 1'b0);

    grant(2);
    check("t4_gerr", grant_err, 1);
    check("t4_en", packet_out_en, 0);
    tick();
    check("t4_gerr_pulse", grant_err, 0);
    check("t4_nonempty", voq_nonempty, 0);
    send(16'h40, 3);
    send(16'h41, 3);
    grant(3);
    expect_block(16'h40, 3, 1'b1);
    check("t4_keep", voq_nonempty, 4'b1000);
    grant(3);
    expect_block(16'h41, 3, 1'b0);

    send(16'h50, 1);
    fork
      begin
        grant(1);
        expect_block(16'h50, 1, 1'b0);
      end
      begin
        repeat (9) tick();
        send(16'h51, 1);
      end
    join
    check("t5_free_swap", dut.free_cnt, 3);
    check("t5_nonempty", voq_nonempty, 4'b0010);
    fork
      send(16'h52, 1);
      begin
        repeat (7) tick();
        grant(1);
        expect_block(16'h51, 1, 1'b0);
      end
    join
    check("t5_same_voq", voq_nonempty, 4'b0010);
    check("t5_free2", dut.free_cnt, 3);
    fork
      send(16'h53, 2);
      begin
        repeat (7) tick();
        grant(2);
        check("t5_gerr_enq", grant_err, 1);
      end
    join
    check("t5_enq_kept", voq_nonempty, 4'b0110);
    grant(1);
    expect_block(16'h52, 1, 1'b0);
    grant(2);
    expect_block(16'h53, 2, 1'b0);
    check("t5_free_end", dut.free_cnt, 4);

    send(16'h60, 0);
    grant(0);
    repeat (3) tick();
    packet_in = wd(16'h61, 1, 0);
    packet_en = 1'b1;
    tick();
    packet_in = wd(16'h61, 1, 1);
    tick();
    reset     = 1'b1;
    packet_en = 1'b0;
    tick();
    check("t6_nonempty", voq_nonempty, 0);
    check("t6_busy", busy_out, 0);
    check("t6_en", packet_out_en, 0);
    check("t6_out", packet_out, 0);
    check("t6_drop", drop_cnt, 0);
    check("t6_gerr", grant_err, 0);
    reset = 1'b0;
    repeat (6) tick();
    check("t6_free", dut.free_cnt, 4);
    send(16'h62, 3);
    check("t6_nonempty2", voq_nonempty, 4'b1000);
    grant(3);
    expect_block(16'h62, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
